instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Upstream stage of the instruction decoder. Holds a small program memory loaded
//  over a write port, steps a program counter and presents one 4-bit opcode plus
//  operand per issue slot. Stalls on request from downstream. Stops on end of
//  program or on an invalid opcode (12-15).
// PARAMETERS
//  ADDR_W  4  program-memory address width; depth = 2**ADDR_W words
//  DATA_W  4  operand width; memory word = {opcode[3:0], operand[DATA_W-1:0]}
// PORTS
//  clk          in   1           single clock; all state changes on rising edge
//  rst          in   1           synchronous, active-high reset
//  prog_we      in   1           program-memory write strobe (honoured only when busy=0)
//  prog_addr    in   ADDR_W      write address
//  prog_wdata   in   4+DATA_W    write word {opcode, operand}
//  prog_len     in   ADDR_W+1    instruction count, sampled on accepted start
//  start        in   1           begin execution at pc=0 (honoured only when busy=0)
//  stall        in   1           downstream not ready; hold current issue
//  instruction  out  4           opcode to decoder; 4'hC (NULL) whenever instr_valid=0
//  data_out     out  DATA_W      operand for the datapath; 0 whenever instr_valid=0
//  instr_valid  out  1           instruction/data_out valid this cycle
//  pc           out  ADDR_W      address of the current/next instruction
//  busy         out  1           FETCH or ISSUE state
//  done         out  1           sticky: program completed normally
//  err          out  1           sticky: invalid opcode fetched
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, instruction=4'hC, data_out=0.
//   instr_valid, busy, done and err are all 0.
//   Memory contents are not reset. Reset mid-run aborts at once; no further issue.
//  States: IDLE, FETCH, ISSUE, DONE, ERR.
//  Memory: synchronous read, 1-cycle latency, address = pc.
//   Write in the same cycle as a read of the same address returns the old data.
//  IDLE/DONE/ERR, start=1:
//   - latch prog_len; clear done and err; pc<=0.
//   - next state FETCH, or DONE if prog_len==0.
//  FETCH: issue read at pc. Next state ISSUE.
//  ISSUE, opcode 0..11:
//   - instr_valid=1; instruction and data_out are driven from the read word.
//   - stall=1: stay in ISSUE with outputs held stable, one instruction per stall window.
//   - stall=0: the issue completes; pc<=pc+1.
//   - Next state DONE if pc+1==latched prog_len, else FETCH.
//  ISSUE, opcode 12..15:
//   - instr_valid stays 0; err<=1; pc is held at the faulting address.
//   - Next state ERR. stall is ignored.
//  Timing: first instr_valid 2 cycles after start is sampled. Without stall,
//   one issue every 2 cycles (FETCH/ISSUE alternate).
//  Boundaries:
//   - prog_len > 2**ADDR_W is saturated to 2**ADDR_W. pc never wraps.
//   - prog_we while busy=1 is dropped; memory is unchanged.
//   - start while busy=1 is ignored.
//   - start and prog_we in the same idle cycle: the write is performed and the
//     run starts; the written word is visible to the first FETCH.
//   - rst has priority over start, stall and prog_we.
// TESTING
//  1 Reset: assert rst 2 cycles with start=1 -> all outputs at their reset values;
//     instruction=4'hC; memory retains preloaded words.
//  2 Load {1,3},{2,5},{4,0}, prog_len=3, start, stall=0 -> instr_valid at T+2, T+4,
//     T+6 carrying (1,3),(2,5),(4,0); done=1 at T+7; pc=3.
//  3 Same program, stall=1 for 3 cycles at the first issue -> (1,3) held 4 cycles,
//     then (2,5) arrives 2 cycles after stall drops; no duplicate or lost issue.
//  4 Load {0,0},{13,7}, prog_len=2 -> opcode 0 issued; then err=1, pc=1,
//     instr_valid never asserted for 13; a later start clears err and reruns.
//  5 prog_len=0, start -> done=1 next cycle, instr_valid never asserted;
//     prog_we while busy -> readback shows memory unchanged.
//  6 rst asserted during a stalled ISSUE -> next cycle IDLE, instr_valid=0, pc=0,
//     done=err=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Program memory + PC sequencer feeding the decoder one {opcode, operand} per issue slot.
// Stops on end of program (done) or on an opcode of 12..15 (err); downstream stall holds the issue.
module instruction_fetch_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [3+DATA_W:0] prog_wdata,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              stall,
  output logic [3:0]        instruction,
  output logic [DATA_W-1:0] data_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WORD_W = 4 + DATA_W;
  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_word;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_sat;
  logic [ADDR_W:0]   pc_inc;
  logic [3:0]        rd_op;
  logic              op_ok;
  logic              idle_like;
  logic              run_start;
  logic              issue_done;

  assign rd_op      = rd_word[WORD_W-1 -: 4];
  assign op_ok      = (rd_op < 4'd12);
  assign idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign run_start  = idle_like && start;
  assign issue_done = (state == S_ISSUE) && op_ok && !stall;
  assign pc_inc     = {1'b0, pc} + 1'b1;
  assign len_sat    = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = (prog_len == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: state_nxt = S_ISSUE;
      S_ISSUE: begin
        // An invalid opcode faults regardless of stall; a valid one waits for it.
        if (!op_ok)      state_nxt = S_ERR;
        else if (!stall) state_nxt = (pc_inc == len_q) ? S_DONE : S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      len_q <= '0;
    end else if (run_start) begin
      pc    <= '0;
      len_q <= len_sat;
    end else if (issue_done && (pc != {ADDR_W{1'b1}})) begin
      pc <= pc + 1'b1;
    end
  end

  // Writes only land while idle, so they can never race the FETCH read.
  always_ff @(posedge clk) begin
    if (!rst && prog_we && !busy) mem[prog_addr] <= prog_wdata;
    if (state == S_FETCH) rd_word <= mem[pc];
  end

  assign busy        = (state == S_FETCH) || (state == S_ISSUE);
  assign done        = (state == S_DONE);
  assign err         = (state == S_ERR);
  assign instr_valid = (state == S_ISSUE) && op_ok;
  assign instruction = instr_valid ? rd_op : 4'hC;
  assign data_out    = instr_valid ? rd_word[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized programs
// checked against an issue-sequence model computed from the memory image.
module tb_instruction_fetch_unit;
  logic       clk = 1'b0;
  logic       rst, prog_we, start, stall;
  logic [3:0] prog_addr;
  logic [7:0] prog_wdata;
  logic [4:0] prog_len;
  logic [3:0] instruction, data_out, pc;
  logic       instr_valid, busy, done, err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model_mem [16];

  instruction_fetch_unit #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start), .stall(stall),
    .instruction(instruction), .data_out(data_out), .instr_valid(instr_valid),
    .pc(pc), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [7:0] w);
    prog_we = 1'b1; prog_addr = a; prog_wdata = w;
    model_mem[a] = w;
    step();
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    write_word(4'd0, 8'h13);
    write_word(4'd1, 8'h25);
    write_word(4'd2, 8'h40);
    rst = 1'b1; start = 1'b1; prog_len = 5'd3;
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if ({instr_valid, instruction, data_out, pc, busy, done, err} !== {1'b0, 4'hC, 4'h0, 4'h0, 3'b000}) begin
        miscompares++;
        $display("FAIL reset_state k=%0d: got v=%b ins=%h d=%h pc=%0d b=%b dn=%b e=%b want 0/C/0/0/0/0/0",
                 k, instr_valid, instruction, data_out, pc, busy, done, err);
      end
    end
    rst = 1'b0; start = 1'b0;
  endtask

  // Runs words 0..2 with no stall; memory must hold what the model holds.
  task automatic test_basic(input string tag);
    logic       v;
    logic [7:0] w;
    prog_len = 5'd3; start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) step();
      v = (k == 2) || (k == 4) || (k == 6);
      w = v ? model_mem[k/2 - 1] : 8'hC0;
      vectors++;
      if ({instr_valid, instruction, data_out} !== {v, w}) begin
        miscompares++;
        $display("FAIL %s_issue k=%0d: got v=%b %h/%h want v=%b %h/%h",
                 tag, k, instr_valid, instruction, data_out, v, w[7:4], w[3:0]);
      end
    end
    vectors++;
    if ({done, busy, err, pc} !== {1'b1, 1'b0, 1'b0, 4'd3}) begin
      miscompares++;
      $display("FAIL %s_end: got done=%b busy=%b err=%b pc=%0d want 1/0/0/3", tag, done, busy, err, pc);
    end
  endtask

  task automatic test_stall();
    logic       v;
    logic [7:0] w;
    prog_len = 5'd3; start = 1'b1; step(); start = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      step();
      v = (k >= 2 && k <= 5) || (k == 7) || (k == 9);
      w = !v ? 8'hC0 : (k <= 5) ? model_mem[0] : (k == 7) ? model_mem[1] : model_mem[2];
      vectors++;
      if ({instr_valid, instruction, data_out} !== {v, w}) begin
        miscompares++;
        $display("FAIL stall_issue k=%0d: got v=%b %h/%h want v=%b %h/%h",
                 k, instr_valid, instruction, data_out, v, w[7:4], w[3:0]);
      end
      stall = (k >= 2) && (k <= 4);
    end
    stall = 1'b0;
    vectors++;
    if ({done, pc} !== {1'b1, 4'd3}) begin
      miscompares++;
      $display("FAIL stall_end: got done=%b pc=%0d want 1/3", done, pc);
    end
  endtask

  task automatic test_error();
    write_word(4'd0, 8'h00);
    write_word(4'd1, 8'hD7);
    for (int run = 0; run < 2; run++) begin
      prog_len = 5'd2; start = 1'b1; step(); start = 1'b0;
      vectors++;
      if ({err, busy} !== 2'b01) begin
        miscompares++;
        $display("FAIL err_cleared run=%0d: got err=%b busy=%b want 0/1", run, err, busy);
      end
      for (int k = 2; k <= 5; k++) begin
        step();
        if (k == 2) begin
          vectors++;
          if ({instr_valid, instruction, data_out} !== 9'h100) begin
            miscompares++;
            $display("FAIL err_first run=%0d: got v=%b %h/%h want v=1 0/0", run, instr_valid, instruction, data_out);
          end
        end else if (k < 5) begin
          vectors++;
          if ({instr_valid, instruction} !== 5'h0C) begin
            miscompares++;
            $display("FAIL err_noissue run=%0d k=%0d: got v=%b ins=%h want v=0 C", run, k, instr_valid, instruction);
          end
        end else begin
          vectors++;
          if ({err, done, busy, instr_valid, pc} !== {4'b1000, 4'd1}) begin
            miscompares++;
            $display("FAIL err_state run=%0d: got err=%b done=%b busy=%b v=%b pc=%0d want 1/0/0/0/1",
                     run, err, done, busy, instr_valid, pc);
          end
        end
      end
    end
  endtask

  task automatic test_zero_len_and_lock();
    int cyc;
    prog_len = 5'd0; start = 1'b1; step(); start = 1'b0;
    vectors++;
    if ({done, busy, err, instr_valid} !== 4'b1000) begin
      miscompares++;
      $display("FAIL zero_len: got done=%b busy=%b err=%b v=%b want 1/0/0/0", done, busy, err, instr_valid);
    end
    write_word(4'd0, 8'h13);
    write_word(4'd1, 8'h25);
    write_word(4'd2, 8'h40);
    prog_len = 5'd3; start = 1'b1; step(); start = 1'b0;
    // Write and restart while busy: both must be dropped.
    prog_we = 1'b1; prog_addr = 4'd1; prog_wdata = 8'h5A; start = 1'b1;
    step();
    prog_we = 1'b0; start = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin step(); cyc++; end
    vectors++;
    if ({busy, done, pc} !== {1'b0, 1'b1, 4'd3}) begin
      miscompares++;
      $display("FAIL lock_end: got busy=%b done=%b pc=%0d want 0/1/3", busy, done, pc);
    end
  endtask

  task automatic test_rst_midrun();
    stall = 1'b1;
    prog_len = 5'd3; start = 1'b1; step(); start = 1'b0;
    step();
    vectors++;
    if (instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: got v=%b want 1", instr_valid);
    end
    rst = 1'b1; step(); rst = 1'b0; stall = 1'b0;
    vectors++;
    if ({instr_valid, instruction, data_out, pc, busy, done, err} !== {1'b0, 4'hC, 4'h0, 4'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL rst_mid: got v=%b ins=%h d=%h pc=%0d b=%b dn=%b e=%b want 0/C/0/0/0/0/0",
               instr_valid, instruction, data_out, pc, busy, done, err);
    end
    step(); step();
    vectors++;
    if ({instr_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_after: got v=%b busy=%b want 0/0", instr_valid, busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] held;
    logic       hold, exp_err, exp_done, s;
    logic [3:0] exp_pc, op;
    logic [4:0] len;
    int         n, cyc;
    for (int it = 0; it < 40; it++) begin
      // Iteration 0 exercises length saturation with an all-valid full memory.
      for (int a = 0; a < 16; a++) begin
        if (it == 0 || $urandom_range(0, 2) == 0) begin
          op = (it != 0 && $urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
          write_word(4'(a), {op, 4'($urandom_range(0, 15))});
        end
      end
      len = (it == 0) ? 5'd31 : 5'($urandom_range(0, 20));
      n = (len > 5'd16) ? 16 : int'(len);
      exp_q.delete(); got_q.delete();
      exp_err = 1'b0; exp_done = 1'b1; exp_pc = (n == 16) ? 4'd15 : 4'(n);
      for (int i = 0; i < n; i++) begin
        if (model_mem[i][7:4] >= 4'd12) begin
          exp_err = 1'b1; exp_done = 1'b0; exp_pc = 4'(i);
          break;
        end
        exp_q.push_back(model_mem[i]);
      end
      prog_len = len; start = 1'b1; step(); start = 1'b0;
      cyc = 0; hold = 1'b0; held = 8'h00;
      while (busy && cyc < 200) begin
        if (hold) begin
          vectors++;
          if ({instr_valid, instruction, data_out} !== {1'b1, held}) begin
            miscompares++;
            $display("FAIL rand_hold it=%0d: got v=%b %h/%h want v=1 %h", it, instr_valid, instruction, data_out, held);
          end
        end
        s = ($urandom_range(0, 2) == 0);
        if (instr_valid && !s) got_q.push_back({instruction, data_out});
        hold = instr_valid && s;
        held = {instruction, data_out};
        stall = s;
        start = ($urandom_range(0, 3) == 0);
        prog_we = ($urandom_range(0, 3) == 0);
        prog_addr = 4'($urandom_range(0, 15));
        prog_wdata = 8'($urandom_range(0, 255));
        step();
        cyc++;
      end
      stall = 1'b0; start = 1'b0; prog_we = 1'b0;
      vectors++;
      if (cyc >= 200) begin
        miscompares++;
        $display("FAIL rand_timeout it=%0d: got busy after %0d cycles want idle", it, cyc);
      end
      vectors++;
      if (got_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL rand_count it=%0d: got %0d issues want %0d", it, got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          vectors++;
          if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL rand_word it=%0d i=%0d: got %h want %h", it, i, got_q[i], exp_q[i]);
          end
        end
      end
      vectors++;
      if ({done, err, pc} !== {exp_done, exp_err, exp_pc}) begin
        miscompares++;
        $display("FAIL rand_end it=%0d len=%0d: got done=%b err=%b pc=%0d want %b/%b/%0d",
                 it, len, done, err, pc, exp_done, exp_err, exp_pc);
      end
    end
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; start = 1'b0; stall = 1'b0;
    prog_addr = '0; prog_wdata = '0; prog_len = '0;
    for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
    step(); step();
    rst = 1'b0;
    test_reset();
    test_basic("basic");
    test_stall();
    test_error();
    test_zero_len_and_lock();
    test_basic("readback");
    test_rst_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
